// File: rtl/step_sequencer.sv
// step_sequencer
//   Stepper-motor coil sequencer. It takes step pulses from an upstream
//   divider and walks an 8-entry phase table, in half-step or full-step
//   (two-phase-on) mode. It also tracks a signed position and runs moves
//   of a requested length.
//
// Ports
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   step    : step pulse (edge-detected; may be held high)
//   dir     : 1 = forward, 0 = reverse
//   half    : 1 = half-step, 0 = full-step
//   en      : coil enable; 0 de-energises coils and aborts a move
//   start   : single-cycle move request
//   n_steps : move length, sampled when start is accepted
//   cnt_en  : run enable to the upstream divider (registered)
//   phase   : coil drive A,B,C,D on bits [0..3] (registered)
//   busy    : move in progress (registered)
//   done    : one-cycle pulse on normal move completion
//   pos     : signed step position, wraps modulo 2^WIDTH
module step_sequencer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step,
    input  logic             dir,
    input  logic             half,
    input  logic             en,
    input  logic             start,
    input  logic [WIDTH-1:0] n_steps,
    output logic             cnt_en,
    output logic [3:0]       phase,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] pos
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    logic [2:0]       idx;
    logic [2:0]       idx_next;
    logic [WIDTH-1:0] remaining;
    logic             step_d;
    logic             step_edge;
    logic             advance;

    function automatic logic [3:0] phase_lut(input logic [2:0] i);
        logic [3:0] p;
        case (i)
            3'd0:    p = 4'b0001;
            3'd1:    p = 4'b0011;
            3'd2:    p = 4'b0010;
            3'd3:    p = 4'b0110;
            3'd4:    p = 4'b0100;
            3'd5:    p = 4'b1100;
            3'd6:    p = 4'b1000;
            default: p = 4'b1001;
        endcase
        return p;
    endfunction

    // The index update is computed here so that phase can load
    // table[idx_next] in the same edge that idx advances.
    always_comb begin
        step_edge = step & ~step_d;
        advance   = (state == RUN) && en && step_edge;
        idx_next  = idx;
        if (advance) begin
            if (half) begin
                idx_next = dir ? idx + 3'd1 : idx - 3'd1;
            end else if (dir) begin
                // A full step from a one-phase-on (even) state moves by one,
                // which snaps it onto a two-phase-on (odd) state.
                idx_next = idx + (idx[0] ? 3'd2 : 3'd1);
            end else begin
                idx_next = idx - (idx[0] ? 3'd2 : 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            pos       <= '0;
            remaining <= '0;
            step_d    <= 1'b0;
            phase     <= '0;
            busy      <= 1'b0;
            cnt_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            step_d <= step;
            done   <= 1'b0;
            idx    <= idx_next;
            phase  <= en ? phase_lut(idx_next) : 4'b0000;

            case (state)
                IDLE: begin
                    if (start && en) begin
                        if (n_steps != '0) begin
                            remaining <= n_steps;
                            state     <= RUN;
                            busy      <= 1'b1;
                            cnt_en    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (!en) begin
                        // Abort: no done pulse, idx and pos are kept.
                        state  <= IDLE;
                        busy   <= 1'b0;
                        cnt_en <= 1'b0;
                    end else if (step_edge) begin
                        pos <= dir ? pos + ONE : pos - ONE;
                        if (remaining != '0) begin
                            remaining <= remaining - ONE;
                        end
                        if (remaining == ONE) begin
                            state  <= IDLE;
                            busy   <= 1'b0;
                            cnt_en <= 1'b0;
                            done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    cnt_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer
//   Self-checking bench for step_sequencer. The stimulus process drives
//   inputs, advances a behavioural model and queues the expected outputs
//   for each clock edge. A monitor pops those entries on the falling edge
//   and compares them against the DUT.
module tb_step_sequencer;

    localparam int unsigned W = 16;

    logic         clk = 1'b0;
    logic         rst, step, dir, half, en, start;
    logic [W-1:0] n_steps;
    logic         cnt_en, busy, done;
    logic [3:0]   phase;
    logic [W-1:0] pos;

    int checks   = 0;
    int failures = 0;

    step_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .step(step), .dir(dir), .half(half), .en(en),
        .start(start), .n_steps(n_steps), .cnt_en(cnt_en), .phase(phase),
        .busy(busy), .done(done), .pos(pos)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   phase;
        logic         busy;
        logic         done;
        logic [W-1:0] pos;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: motor position in table index terms plus move bookkeeping.
    logic [3:0] tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};
    int           m_idx, m_left;
    bit           m_moving, m_prev, m_done;
    logic [W-1:0] m_pos;
    logic [3:0]   m_phase;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_step();
        int delta;
        if (rst) begin
            m_idx = 0; m_pos = '0; m_left = 0; m_moving = 0;
            m_prev = 0; m_done = 0; m_phase = 4'b0000;
        end else begin
            m_done = 0;
            if (!m_moving) begin
                if (start && en) begin
                    if (n_steps == 0) m_done = 1;
                    else begin m_moving = 1; m_left = int'(n_steps); end
                end
            end else if (!en) begin
                m_moving = 0;
            end else if (step && !m_prev) begin
                // Full step lands on the next odd (two-phase-on) entry.
                if (half) delta = 1;
                else      delta = (m_idx % 2 == 1) ? 2 : 1;
                m_idx = dir ? (m_idx + delta) % 8 : (m_idx + 8 - delta) % 8;
                m_pos = dir ? m_pos + W'(1) : m_pos - W'(1);
                m_left--;
                if (m_left == 0) begin m_moving = 0; m_done = 1; end
            end
            m_prev  = step;
            m_phase = en ? tbl[m_idx] : 4'b0000;
        end
    endtask

    task automatic tick();
        exp_t e;
        model_step();
        @(posedge clk);
        e.phase = m_phase; e.busy = m_moving; e.done = m_done; e.pos = m_pos;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic pulse();
        step = 1'b1; tick();
        step = 1'b0; tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; step = 1'b0; start = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("phase",  32'(phase),  32'(e.phase));
            chk("busy",   32'(busy),   32'(e.busy));
            chk("cnt_en", 32'(cnt_en), 32'(e.busy));
            chk("done",   32'(done),   32'(e.done));
            chk("pos",    32'(pos),    32'(e.pos));
        end
    end

    initial begin
        rst = 1'b1; step = 1'b0; dir = 1'b1; half = 1'b1; en = 1'b1;
        start = 1'b0; n_steps = '0;
        do_reset();

        // First edge after reset release with coils enabled.
        tick();
        chk("rst_release_phase", 32'(phase), 32'h1);
        chk("rst_release_pos",   32'(pos),   32'h0);
        chk("rst_release_busy",  32'(busy),  32'h0);

        // Half-step forward move of 10.
        half = 1'b1; dir = 1'b1; start = 1'b1; n_steps = 16'd10; tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) pulse();
        chk("half10_phase", 32'(phase), 32'b0010);
        chk("half10_pos",   32'(pos),   32'd10);

        // Full-step reverse move of 3 from index 0.
        do_reset();
        half = 1'b0; dir = 1'b0; en = 1'b1; start = 1'b1; n_steps = 16'd3; tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) pulse();
        chk("full_rev_phase", 32'(phase), 32'b0110);
        chk("full_rev_pos",   32'(pos),   32'hFFFD);

        // Step held high for 50 cycles counts once.
        do_reset();
        half = 1'b1; dir = 1'b1; start = 1'b1; n_steps = 16'd3; tick();
        start = 1'b0; step = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        step = 1'b0; tick();
        chk("held_step_pos",  32'(pos),  32'd1);
        chk("held_step_busy", 32'(busy), 32'd1);
        pulse(); pulse();

        // Abort by dropping en after 4 of 8 steps.
        do_reset();
        start = 1'b1; n_steps = 16'd8; tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) pulse();
        en = 1'b0; tick();
        chk("abort_phase",  32'(phase),  32'h0);
        chk("abort_busy",   32'(busy),   32'h0);
        chk("abort_cnt_en", 32'(cnt_en), 32'h0);
        chk("abort_done",   32'(done),   32'h0);
        chk("abort_pos",    32'(pos),    32'd4);
        start = 1'b1; n_steps = 16'd2; tick();   // ignored while en=0
        start = 1'b0; en = 1'b1; tick();

        // Zero-length move.
        start = 1'b1; n_steps = '0; tick();
        start = 1'b0;
        chk("zero_move_done", 32'(done), 32'h1);
        chk("zero_move_busy", 32'(busy), 32'h0);
        tick();

        // Reset mid-move.
        start = 1'b1; n_steps = 16'd5; tick();
        start = 1'b0; pulse();
        rst = 1'b1; step = 1'b1; start = 1'b1; tick();
        chk("mid_rst_phase", 32'(phase), 32'h0);
        chk("mid_rst_pos",   32'(pos),   32'h0);
        chk("mid_rst_busy",  32'(busy),  32'h0);
        chk("mid_rst_done",  32'(done),  32'h0);
        rst = 1'b0; step = 1'b0; start = 1'b0; tick();

        // Randomised traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            rst     = ($urandom_range(0, 399) == 0);
            en      = ($urandom_range(0, 49) != 0);
            start   = ($urandom_range(0, 9) == 0);
            n_steps = W'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) dir  = ~dir;
            if ($urandom_range(0, 19) == 0) half = ~half;
            if ($urandom_range(0, 2) == 0)  step = ~step;
            tick();
        end

        rst = 1'b0; start = 1'b0; step = 1'b0;
        tick(); tick();
        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, width of step count and position.
REQ-002 clk  input  1  system clock; all logic on rising edge; the only clock.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 step  input  1  step pulse from the upstream divider; may stay high for many cycles.
REQ-005 dir  input  1  direction: 1 = forward (index up), 0 = reverse.
REQ-006 half  input  1  mode: 1 = half-step, 0 = full-step (two-phase-on).
REQ-007 en  input  1  coil enable; 0 de-energises coils.
REQ-008 start  input  1  single-cycle request to begin a move.
REQ-009 n_steps  input  WIDTH  move length; sampled only when start is accepted.
REQ-010 cnt_en  output  1  run enable to the upstream divider.
REQ-011 phase  output  4  coil drive A,B,C,D as bits [0..3].
REQ-012 busy  output  1  high while a move is in progress.
REQ-013 done  output  1  one-cycle pulse on normal move completion.
REQ-014 pos  output  WIDTH  signed step position, two's complement.

Function
REQ-015 Step edge detection: a step edge occurs at a clock edge where step=1 and the previous sample of step was 0; a held-high step yields exactly one edge.
REQ-016 Phase table, 3-bit index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001.
REQ-017 Half mode: a forward edge sets idx = idx+1 mod 8; a reverse edge sets idx = idx-1 mod 8.
REQ-018 Full mode, forward, odd idx: a step edge sets idx = idx+2 mod 8.
REQ-019 Full mode, forward, even idx: a step edge sets idx = idx+1, which snaps to a two-phase-on state.
REQ-020 Full mode, reverse: odd idx gives idx-2 mod 8; even idx gives idx-1 mod 8.
REQ-021 FSM states are IDLE and RUN.
REQ-022 IDLE: step edges are ignored; idx and pos hold.
REQ-023 IDLE with start=1, en=1 and n_steps>0: latch remaining=n_steps and go to RUN on the next edge.
REQ-024 IDLE with start=1 and n_steps=0: stay in IDLE and pulse done for one cycle on the next edge.
REQ-025 RUN: busy=1 and cnt_en=1; both are registered and equal to (state==RUN).
REQ-026 RUN, each step edge: update idx per REQ-017..020, pos += 1 (forward) or -= 1 (reverse), and remaining -= 1; one edge always counts as one step in either mode.
REQ-027 RUN, a step edge with remaining=1: move to IDLE; in the following cycle done=1 and busy=0.
REQ-028 start while in RUN is ignored; dir and half changes mid-move take effect at the next step edge.
REQ-029 en=0 while in RUN aborts the move: go to IDLE at the next edge with no done pulse; idx and pos keep their last values.
REQ-030 start while en=0 is ignored.
REQ-031 phase is registered: each cycle it is loaded with table[idx after this edge's update] when en=1, and with 0000 when en=0.
REQ-032 phase therefore follows a step edge with one cycle of latency.
REQ-033 pos wraps modulo 2^WIDTH with no saturation.
REQ-034 remaining is never decremented below 0.

Reset
REQ-035 rst=1 at a clock edge, in any state including mid-move, forces: state=IDLE, idx=0, pos=0, remaining=0, step history=0, phase=0000, busy=0, cnt_en=0, done=0.
REQ-036 rst has priority over start, step and en in the same cycle.
REQ-037 Reset mid-move produces no done pulse.

Verification
REQ-038 Reset release with en=1 and no step -> phase=0001 on the first edge after reset; pos=0, busy=0.
REQ-039 half=1, dir=1, start with n_steps=10, 10 step edges -> phase walks 0011, 0010 ... ending at 0010 (idx=2); pos=10; done high exactly 1 cycle; busy falls in the same cycle as done.
REQ-040 half=0, dir=0, idx=0, n_steps=3 -> idx goes 7, 5, 3; phase 1001, 1100, 0110; pos=-3 (0xFFFD).
REQ-041 step held high for 50 cycles in RUN -> exactly one step counted; remaining decrements by 1.
REQ-042 en dropped after 4 of 8 steps -> phase=0000 next cycle; FSM returns to IDLE with no done pulse; pos=4; cnt_en=0.
REQ-043 start with n_steps=0 -> done pulse next cycle and busy never asserts.
REQ-044 rst asserted mid-move -> all outputs reach their REQ-035 values on that edge with no done pulse.
